// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, error codes and pointer sizing for the packet router
package router_pkg;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, SEND} state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DEST = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_SUM  = 2'b11;

  // Pointer counts 0..maxLen inclusive
  function automatic int ptrWidth(input int maxLen);
    return $clog2(maxLen + 1);
  endfunction

  // Buffer address only needs to reach maxLen-1
  function automatic int bufAddrWidth(input int maxLen);
    return maxLen > 1 ? $clog2(maxLen) : 1;
  endfunction

endpackage

// File: rtl/packet_buffer.sv
// packet_buffer: unreset payload register file, one write port and a combinational read port
module packet_buffer #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MAX_LEN];

  // Store one payload word per accepted write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_router_n.sv
// packet_router_n: store-and-forward packet router with checksum, length and destination validation
module packet_router_n
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 4,
  parameter int MAX_LEN   = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     pkt_sent,
  output logic [CNT_W-1:0]     pkt_dropped,
  output logic                 busy
);

  localparam int PTR_W  = ptrWidth(MAX_LEN);
  localparam int ADDR_W = bufAddrWidth(MAX_LEN);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam logic [DATA_W-1:0] maxLenW   = DATA_W'(MAX_LEN);
  localparam logic [DATA_W-1:0] numPortsW = DATA_W'(NUM_PORTS);

  state_t              state;
  logic [DATA_W-1:0]   dest;
  logic [DATA_W-1:0]   acc;
  logic [PTR_W-1:0]    lastIdx;
  logic [PTR_W-1:0]    wrPtr;
  logic [PTR_W-1:0]    rdPtr;
  logic [DATA_W-1:0]   rdData;
  logic [PORT_W-1:0]   portSel;
  logic [1:0]          dropCode;
  logic                inFire;
  logic                outFire;
  logic                lastWord;

  assign in_ready = state != SEND;
  assign busy     = state != IDLE;
  assign inFire   = in_valid && in_ready;
  assign portSel  = dest[PORT_W-1:0];
  assign outFire  = state == SEND && out_ready[portSel];
  assign lastWord = rdPtr == lastIdx;

  assign out_valid = state == SEND ? NUM_PORTS'(1) << portSel : '0;
  assign out_data  = state == SEND ? rdData : '0;
  assign out_last  = state == SEND && lastWord;

  // Checksum is judged before the destination, so a corrupted dest word reports a sum error
  assign dropCode = !inFire ? ERR_NONE :
                    state == LEN ? ((in_data == '0 || in_data > maxLenW) ? ERR_LEN : ERR_NONE) :
                    state == CHECK ? (acc != in_data ? ERR_SUM : dest >= numPortsW ? ERR_DEST : ERR_NONE) :
                    ERR_NONE;

  packet_buffer #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk  (clock),
    .we   (state == PAYLOAD && inFire),
    .waddr(wrPtr[ADDR_W-1:0]),
    .wdata(in_data),
    .raddr(rdPtr[ADDR_W-1:0]),
    .rdata(rdData)
  );

  // Receive/validate/forward sequencer with drop handling and saturating statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dest        <= '0;
      acc         <= '0;
      lastIdx     <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_NONE;
      pkt_sent    <= '0;
      pkt_dropped <= '0;
    end else begin
      err_pulse <= dropCode != ERR_NONE;
      if (dropCode != ERR_NONE) begin
        err_code <= dropCode;
        if (~&pkt_dropped) pkt_dropped <= pkt_dropped + CNT_W'(1);
        state <= IDLE;
        acc   <= '0;
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        case (state)
          IDLE: if (inFire) begin
            dest  <= in_data;
            acc   <= in_data;
            state <= LEN;
          end
          LEN: if (inFire) begin
            lastIdx <= PTR_W'(in_data - DATA_W'(1));
            acc     <= acc + in_data;
            state   <= PAYLOAD;
          end
          PAYLOAD: if (inFire) begin
            wrPtr <= wrPtr + PTR_W'(1);
            acc   <= acc + in_data;
            if (wrPtr == lastIdx) state <= CHECK;
          end
          CHECK: if (inFire) state <= SEND;
          SEND: if (outFire) begin
            rdPtr <= rdPtr + PTR_W'(1);
            if (lastWord) begin
              if (~&pkt_sent) pkt_sent <= pkt_sent + CNT_W'(1);
              rdPtr <= '0;
              wrPtr <= '0;
              acc   <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_router_n.sv
// tb_packet_router_n: scenario tasks with a scoreboard of expected port words and error codes
module tb_packet_router_n;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic [7:0]  out_data;
  logic        out_last;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] pkt_sent;
  logic [15:0] pkt_dropped;
  logic        busy;

  typedef struct packed {
    logic [3:0] vld;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       sbQ[$];
  logic [1:0] errQ[$];
  int         passCnt = 0;
  int         totalCnt = 0;

  packet_router_n dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .pkt_sent   (pkt_sent),
    .pkt_dropped(pkt_dropped),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Monitor: every accepted output word and every error pulse is matched against the scoreboard
  always @(negedge clock) begin : mon
    exp_t       e;
    logic [1:0] c;
    if (reset) begin
      if (|(out_valid & out_ready)) begin
        totalCnt++;
        if (sbQ.size() == 0) begin
          $display("FAIL out_word unexpected: valid=%b data=%h last=%b required none", out_valid, out_data, out_last);
        end else begin
          e = sbQ.pop_front();
          if (out_valid !== e.vld || out_data !== e.data || out_last !== e.last)
            $display("FAIL out_word: got valid=%b data=%h last=%b required valid=%b data=%h last=%b",
                     out_valid, out_data, out_last, e.vld, e.data, e.last);
          else passCnt++;
        end
      end
      if (err_pulse === 1'b1) begin
        totalCnt++;
        if (errQ.size() == 0) begin
          $display("FAIL err_pulse unexpected: code=%b required no error", err_code);
        end else begin
          c = errQ.pop_front();
          if (err_code !== c) $display("FAIL err_code: got %b required %b", err_code, c);
          else passCnt++;
        end
      end
    end
  end

  task automatic putWord(input logic [7:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      totalCnt++;
      $display("FAIL put_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Words are packed first-word-most-significant; the model derives expectations before driving
  task automatic sendPkt(input logic [95:0] pk, input int n);
    logic [7:0] w [12];
    logic [7:0] s;
    int         l;
    for (int i = 0; i < n; i++) w[i] = pk[8*(n-1-i) +: 8];
    l = int'(w[1]);
    if (l == 0 || l > 8) begin
      errQ.push_back(2'b10);
    end else begin
      s = 8'h00;
      for (int i = 0; i < l + 2; i++) s = s + w[i];
      if (s != w[l+2]) errQ.push_back(2'b11);
      else if (w[0] >= 8'd4) errQ.push_back(2'b01);
      else for (int i = 0; i < l; i++) sbQ.push_back(exp_t'{4'b0001 << w[0][1:0], w[i+2], i == l - 1});
    end
    for (int i = 0; i < n; i++) putWord(w[i]);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (busy || sbQ.size() != 0 || errQ.size() != 0); t++) begin
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    totalCnt++;
    if (busy !== 1'b0 || sbQ.size() != 0 || errQ.size() != 0)
      $display("FAIL drain: busy=%b pending_words=%0d pending_errs=%0d required 0/0/0", busy, sbQ.size(), errQ.size());
    else passCnt++;
  endtask

  task automatic test_reset();
    #12;
    totalCnt++;
    if ({in_ready, out_valid, out_data, out_last, err_pulse, err_code, busy} !== {1'b1, 4'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0})
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h last=%b pulse=%b code=%b busy=%b required 1/0000/00/0/0/00/0",
               in_ready, out_valid, out_data, out_last, err_pulse, err_code, busy);
    else passCnt++;
    totalCnt++;
    if (pkt_sent !== 16'd0 || pkt_dropped !== 16'd0)
      $display("FAIL reset_counters: sent=%0d dropped=%0d required 0/0", pkt_sent, pkt_dropped);
    else passCnt++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_good();
    out_ready = 4'hF;
    sendPkt({8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65}, 6);
    totalCnt++;
    if (out_valid !== 4'b0100 || in_ready !== 1'b0)
      $display("FAIL good_latency: vld=%b rdy=%b required 0100/0", out_valid, in_ready);
    else passCnt++;
    drain();
    totalCnt++;
    if (pkt_sent !== 16'd1 || pkt_dropped !== 16'd0 || err_code !== 2'b00)
      $display("FAIL good_stats: sent=%0d dropped=%0d code=%b required 1/0/00", pkt_sent, pkt_dropped, err_code);
    else passCnt++;
  endtask

  task automatic test_bad_sum();
    sendPkt({8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h66}, 6);
    totalCnt++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL badsum_idle: vld=%b rdy=%b busy=%b required 0000/1/0", out_valid, in_ready, busy);
    else passCnt++;
    drain();
    totalCnt++;
    if (pkt_dropped !== 16'd1 || err_code !== 2'b11 || pkt_sent !== 16'd1)
      $display("FAIL badsum_stats: dropped=%0d code=%b sent=%0d required 1/11/1", pkt_dropped, err_code, pkt_sent);
    else passCnt++;
  endtask

  task automatic test_bad_dest();
    sendPkt({8'h05, 8'h01, 8'hAA, 8'hB0}, 4);
    totalCnt++;
    if (out_valid !== 4'b0000 || out_data !== 8'h00)
      $display("FAIL baddest_ports: vld=%b data=%h required 0000/00", out_valid, out_data);
    else passCnt++;
    drain();
    totalCnt++;
    if (pkt_dropped !== 16'd2 || err_code !== 2'b01)
      $display("FAIL baddest_stats: dropped=%0d code=%b required 2/01", pkt_dropped, err_code);
    else passCnt++;
  endtask

  task automatic test_bad_len();
    sendPkt({8'h01, 8'h09}, 2);
    totalCnt++;
    if (busy !== 1'b0 || err_pulse !== 1'b1)
      $display("FAIL badlen_edge: busy=%b pulse=%b required 0/1", busy, err_pulse);
    else passCnt++;
    sendPkt({8'h01, 8'h01, 8'h55, 8'h57}, 4);
    totalCnt++;
    if (out_valid !== 4'b0010 || out_data !== 8'h55 || out_last !== 1'b1)
      $display("FAIL badlen_next: vld=%b data=%h last=%b required 0010/55/1", out_valid, out_data, out_last);
    else passCnt++;
    drain();
    totalCnt++;
    if (pkt_dropped !== 16'd3 || pkt_sent !== 16'd2 || err_code !== 2'b10)
      $display("FAIL badlen_stats: dropped=%0d sent=%0d code=%b required 3/2/10", pkt_dropped, pkt_sent, err_code);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic       prevReady;
    logic [7:0] prevData;
    int         holdErr;
    int         rdyErr;
    holdErr = 0;
    rdyErr = 0;
    out_ready = 4'b0111;
    sendPkt({8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hF1}, 7);
    for (int i = 0; i < 40 && busy; i++) begin
      if (in_ready !== 1'b0) rdyErr++;
      prevReady = out_ready[3];
      prevData  = out_data;
      @(posedge clock);
      #1;
      if (!prevReady && busy && out_data !== prevData) holdErr++;
      in_valid     = i == 2;
      in_data      = 8'hEE;
      out_ready[3] = i[0];
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    totalCnt++;
    if (holdErr != 0 || rdyErr != 0)
      $display("FAIL backpressure: hold_errors=%0d ready_errors=%0d required 0/0", holdErr, rdyErr);
    else passCnt++;
    drain();
    totalCnt++;
    if (pkt_sent !== 16'd3 || pkt_dropped !== 16'd3 || in_ready !== 1'b1)
      $display("FAIL backpressure_stats: sent=%0d dropped=%0d rdy=%b required 3/3/1", pkt_sent, pkt_dropped, in_ready);
    else passCnt++;
  endtask

  task automatic test_reset_mid();
    putWord(8'h00);
    putWord(8'h03);
    putWord(8'h11);
    putWord(8'h22);
    reset = 1'b0;
    #1;
    totalCnt++;
    if ({in_ready, out_valid, out_data, out_last, err_pulse, err_code, busy} !== {1'b1, 4'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0} ||
        pkt_sent !== 16'd0 || pkt_dropped !== 16'd0)
      $display("FAIL midreset: rdy=%b vld=%b code=%b busy=%b sent=%0d dropped=%0d required 1/0000/00/0/0/0",
               in_ready, out_valid, err_code, busy, pkt_sent, pkt_dropped);
    else passCnt++;
    @(negedge clock);
    reset = 1'b1;
    sendPkt({8'h00, 8'h02, 8'h7F, 8'h80, 8'h01}, 5);
    drain();
    totalCnt++;
    if (pkt_sent !== 16'd1 || pkt_dropped !== 16'd0)
      $display("FAIL midreset_after: sent=%0d dropped=%0d required 1/0", pkt_sent, pkt_dropped);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_sum();
    test_bad_dest();
    test_bad_len();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
